// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arm_mem_pkg
//  Purpose  : Shared types and encodings for the CPU/graphics RAM arbiter.
//  Revision : 1.0  - initial release
// ============================================================================
package arm_mem_pkg;

    typedef enum logic [0:0] {
        ARB       = 1'b0,
        GFX_BURST = 1'b1
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_GFX  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : arb_starve_cnt
//  Purpose  : Saturating count of cycles the graphics port waited behind the CPU.
//  Revision : 1.0  - initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int MAX = 8,
    parameter int W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_sat
);

    localparam logic [W-1:0] c_max = W'(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/arm_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : arm_mem_arbiter
//  Purpose  : CPU-priority arbiter for a shared single-port RAM with a
//             starvation-triggered bounded graphics burst.
//  Revision : 1.0  - initial release
// ============================================================================
module arm_mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int GFX_MAX_WAIT = 8,
    parameter int BURST_LEN    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              gfx_req,
    input  logic              gfx_we,
    input  logic [ADDR_W-1:0] gfx_addr,
    input  logic [DATA_W-1:0] gfx_wdata,
    output logic              gfx_gnt,
    output logic              gfx_rvalid,
    output logic [DATA_W-1:0] gfx_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [4:0] c_burst_len = 5'(BURST_LEN);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [4:0] r_beat_cnt;
    logic [4:0] w_beat_nxt;
    logic [1:0] w_owner;
    logic       w_wait_clr;
    logic       w_wait_inc;
    logic       w_wait_sat;
    logic       r_cpu_rvalid;
    logic       r_gfx_rvalid;

    arb_starve_cnt #(
        .MAX (GFX_MAX_WAIT),
        .W   (8)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (reset),
        .i_clr (w_wait_clr),
        .i_inc (w_wait_inc),
        .o_sat (w_wait_sat)
    );

    always_comb begin
        w_owner     = OWN_NONE;
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_wait_clr  = 1'b0;
        w_wait_inc  = 1'b0;
        case (r_state)
            ARB: begin
                if (w_wait_sat && gfx_req) begin
                    // Starved long enough: this grant is the first beat of the burst.
                    w_owner    = OWN_GFX;
                    w_beat_nxt = 5'd1;
                    if (BURST_LEN == 1) begin
                        w_wait_clr = 1'b1;
                    end else begin
                        w_state_nxt = GFX_BURST;
                    end
                end else if (cpu_req) begin
                    w_owner    = OWN_CPU;
                    w_wait_inc = gfx_req;
                end else if (gfx_req) begin
                    w_owner    = OWN_GFX;
                    w_wait_clr = 1'b1;
                end
            end
            GFX_BURST: begin
                if (gfx_req) begin
                    w_owner    = OWN_GFX;
                    w_beat_nxt = r_beat_cnt + 5'd1;
                    if (w_beat_nxt == c_burst_len) begin
                        w_state_nxt = ARB;
                        w_wait_clr  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ARB;
                    w_wait_clr  = 1'b1;
                end
            end
            default: w_state_nxt = ARB;
        endcase
        if (reset) begin
            w_owner = OWN_NONE;
        end
    end

    assign cpu_gnt   = (w_owner == OWN_CPU);
    assign gfx_gnt   = (w_owner == OWN_GFX);
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_owner)
            OWN_CPU: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_GFX: begin
                mem_en    = 1'b1;
                mem_we    = gfx_we;
                mem_addr  = gfx_addr;
                mem_wdata = gfx_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB;
            r_beat_cnt   <= 5'd0;
            r_cpu_rvalid <= 1'b0;
            r_gfx_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_beat_nxt;
            r_cpu_rvalid <= cpu_gnt & ~cpu_we;
            r_gfx_rvalid <= gfx_gnt & ~gfx_we;
        end
    end

    // RAM output is registered, so the returning word lines up with rvalid.
    assign cpu_rvalid = r_cpu_rvalid;
    assign gfx_rvalid = r_gfx_rvalid;
    assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : '0;
    assign gfx_rdata  = r_gfx_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_arm_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arm_mem_arbiter
//  Purpose  : Directed self-checking bench for arm_mem_arbiter.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_arm_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        gfx_req, gfx_we, gfx_gnt, gfx_rvalid;
    logic [15:0] gfx_addr;
    logic [31:0] gfx_wdata, gfx_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    arm_mem_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (32),
        .GFX_MAX_WAIT (8),
        .BURST_LEN    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .gfx_req    (gfx_req),
        .gfx_we     (gfx_we),
        .gfx_addr   (gfx_addr),
        .gfx_wdata  (gfx_wdata),
        .gfx_gnt    (gfx_gnt),
        .gfx_rvalid (gfx_rvalid),
        .gfx_rdata  (gfx_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
        gfx_req   = 1'b0; gfx_we = 1'b0; gfx_addr = 16'h0; gfx_wdata = 32'h0;
        mem_rdata = 32'h0000_002A;
        tick();
        cpu_req = 1'b1;
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_gfx_rvalid", 32'(gfx_rvalid), 32'd0);
        tick();
        reset = 1'b0;

        // CPU read of 0x0010
        cpu_we = 1'b0; cpu_addr = 16'h0010;
        #1;
        chk("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("t1_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("t1_mem_en", 32'(mem_en), 32'd1);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t1_cpu_rdata", cpu_rdata, 32'h0000_002A);
        chk("t1_gfx_rvalid", 32'(gfx_rvalid), 32'd0);
        chk("t1_idle_mem_en", 32'(mem_en), 32'd0);
        tick();
        chk("t1_rvalid_drop", 32'(cpu_rvalid), 32'd0);
        chk("t1_rdata_zero", cpu_rdata, 32'h0);

        // Graphics write alone
        gfx_req = 1'b1; gfx_we = 1'b1; gfx_addr = 16'h0100; gfx_wdata = 32'hFF00_FF00;
        #1;
        chk("t2_gfx_gnt", 32'(gfx_gnt), 32'd1);
        chk("t2_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("t2_mem_we", 32'(mem_we), 32'd1);
        chk("t2_mem_addr", 32'(mem_addr), 32'h0100);
        chk("t2_mem_wdata", mem_wdata, 32'hFF00_FF00);
        tick();
        gfx_req = 1'b0;
        #1;
        chk("t2_gfx_rvalid", 32'(gfx_rvalid), 32'd0);
        chk("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("t2_idle_mem_addr", 32'(mem_addr), 32'h0);

        // Both requesting continuously: 8 CPU, 4 GFX burst, CPU again
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_wdata = 32'h1111_1111;
        gfx_req = 1'b1; gfx_we = 1'b0; gfx_addr = 16'h0200; gfx_wdata = 32'h2222_2222;
        for (int c = 1; c <= 13; c++) begin
            #1;
            chk($sformatf("t3_cpu_gnt_c%0d", c), 32'(cpu_gnt), 32'((c <= 8) || (c == 13)));
            chk($sformatf("t3_gfx_gnt_c%0d", c), 32'(gfx_gnt), 32'((c >= 9) && (c <= 12)));
            chk($sformatf("t3_stall_c%0d", c), 32'(cpu_stall), 32'((c >= 9) && (c <= 12)));
            chk($sformatf("t3_cpu_rv_c%0d", c), 32'(cpu_rvalid), 32'((c >= 2) && (c <= 9)));
            chk($sformatf("t3_gfx_rv_c%0d", c), 32'(gfx_rvalid), 32'((c >= 10) && (c <= 13)));
            if (c == 10) chk("t3_burst_addr", 32'(mem_addr), 32'h0200);
            if (c == 13) chk("t3_wait_cleared", 32'(dut.u_starve_cnt.r_cnt), 32'd0);
            tick();
        end

        // Lone graphics access clears the wait count again
        cpu_req = 1'b0;
        #1;
        chk("t4_pre_gfx_gnt", 32'(gfx_gnt), 32'd1);
        tick();

        // Forced burst with gfx_req dropped after two beats
        cpu_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            gfx_req = (c <= 10);
            #1;
            chk($sformatf("t4_cpu_gnt_c%0d", c), 32'(cpu_gnt), 32'((c <= 8) || (c == 12)));
            chk($sformatf("t4_gfx_gnt_c%0d", c), 32'(gfx_gnt), 32'((c == 9) || (c == 10)));
            if (c == 11) chk("t4_drop_mem_en", 32'(mem_en), 32'd0);
            tick();
        end

        // Reset on the second burst beat after a graphics read on the first
        cpu_req = 1'b0; gfx_req = 1'b1;
        tick();
        cpu_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            #1;
            if (c == 9) chk("t5_beat1_gfx_gnt", 32'(gfx_gnt), 32'd1);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("t5_rst_mem_en", 32'(mem_en), 32'd0);
        chk("t5_rst_gfx_gnt", 32'(gfx_gnt), 32'd0);
        chk("t5_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("t5_beat1_rvalid", 32'(gfx_rvalid), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("t5_gfx_rvalid", 32'(gfx_rvalid), 32'd0);
        chk("t5_state", 32'(dut.r_state), 32'(arm_mem_pkg::ARB));
        chk("t5_wait_cnt", 32'(dut.u_starve_cnt.r_cnt), 32'd0);
        chk("t5_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();

        // Alternating CPU read/write, no graphics traffic
        cpu_req = 1'b0; gfx_req = 1'b0;
        tick();
        cpu_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cpu_we    = c[0];
            cpu_addr  = 16'(c);
            cpu_wdata = 32'(c) + 32'h100;
            #1;
            chk($sformatf("t6_stall_c%0d", c), 32'(cpu_stall), 32'd0);
            chk($sformatf("t6_mem_we_c%0d", c), 32'(mem_we), 32'(c % 2));
            chk($sformatf("t6_rvalid_c%0d", c), 32'(cpu_rvalid), 32'(c % 2));
            tick();
        end
        cpu_req = 1'b0;
        #1;
        chk("t6_final_rvalid", 32'(cpu_rvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arm_mem_arbiter.md
Name: arm_mem_arbiter

Overview:
- Shares one single-port data RAM between the ARM core's data port and the 2D graphics engine's pixel port.
- The CPU has default priority. A starvation counter forces a bounded graphics burst so the drawing engine always makes progress.
- When the CPU is blocked, the arbiter raises cpu_stall, which the core uses to freeze its PC and pipeline.
- Sits between the ARM top level (ALUResult/WriteData/MemWrite/ReadData) and the shared RAM.

Parameters:
- ADDR_W, 16, word-address width of the shared RAM
- DATA_W, 32, data width
- GFX_MAX_WAIT, 8, consecutive ungranted gfx_req cycles before a forced graphics burst (1..255)
- BURST_LEN, 4, maximum beats in a forced graphics burst (1..16)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write (MemWrite)
- cpu_addr  in  ADDR_W  address (ALUResult word index)
- cpu_wdata  in  DATA_W  write data (WriteData)
- cpu_gnt  out  1  access issued to RAM this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  read data valid
- cpu_rdata  out  DATA_W  read data (ReadData)
- gfx_req, gfx_we, gfx_addr, gfx_wdata  in  1/1/ADDR_W/DATA_W  graphics request, same meaning as the CPU fields
- gfx_gnt, gfx_rvalid  out  1  graphics grant / read valid
- gfx_rdata  out  DATA_W  graphics read data
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, registered, valid 1 cycle after a read issue

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All state is updated on the rising edge of clk.
- Reset values:
  - state = ARB, wait_cnt = 0, beat_cnt = 0.
  - cpu_rvalid = gfx_rvalid = 0.
  - Grants, mem_en and mem_we are 0 during the reset cycle.
  - A reset asserted mid-burst aborts the burst. An in-flight read's rvalid is dropped.
- Grants and mem_* outputs are combinational from the current state and requests. At most one grant per cycle.
- Not-granted mem outputs: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- mem_* muxing: mem_* is driven from the granted requester; mem_we = granted we.
- State ARB:
  - If wait_cnt == GFX_MAX_WAIT and gfx_req = 1: grant gfx, beat_cnt <= 1, go to GFX_BURST (if BURST_LEN = 1, stay in ARB with wait_cnt <= 0).
  - Else if cpu_req = 1: grant cpu. If gfx_req = 1, wait_cnt increments, saturating at GFX_MAX_WAIT.
  - Else if gfx_req = 1: grant gfx, wait_cnt <= 0.
  - Else: idle; wait_cnt holds.
- State GFX_BURST:
  - If gfx_req = 1: grant gfx, beat_cnt++. On the beat where beat_cnt reaches BURST_LEN, return to ARB with wait_cnt <= 0.
  - If gfx_req = 0: no grant this cycle; return to ARB, wait_cnt <= 0.
  - cpu_gnt = 0 throughout the burst, so cpu_stall = cpu_req.
- Read return:
  - cpu_rvalid <= cpu_gnt & ~cpu_we (registered, latency exactly 1 cycle). gfx_rvalid is the same for gfx.
  - cpu_rdata = mem_rdata when cpu_rvalid, else 0. gfx_rdata is the same.
- Writes produce no rvalid.
- Back-to-back grants to the same requester are allowed every cycle; throughput is 1 access per cycle.
- Simultaneous requests with wait_cnt < GFX_MAX_WAIT: the CPU wins.
- A requester must hold req, we, addr and wdata stable until granted. The arbiter does not latch request fields.

Decomposition:
- Package arm_mem_pkg:
  - typedef enum logic {ARB, GFX_BURST} arb_state_t
  - localparam owner encoding OWN_NONE, OWN_CPU, OWN_GFX (2-bit)
- Sub-module arb_starve_cnt: saturating wait counter with clear/inc/sat output. Everything else stays in arm_mem_arbiter.

Test Plan:
- Reset, then cpu_req read of addr 0x0010 with mem_rdata = 0x0000002A -> cpu_gnt same cycle; next cycle cpu_rvalid = 1, cpu_rdata = 0x2A; cpu_stall = 0.
- gfx_req alone, write addr 0x0100 data 0xFF00FF00 -> gfx_gnt = 1, mem_we = 1, mem_addr = 0x0100, mem_wdata = 0xFF00FF00; no rvalid on either port.
- cpu_req and gfx_req both held continuously -> cpu granted for 8 cycles; cycles 9-12 gfx granted with cpu_stall = 1; cycle 13 cpu granted again with wait_cnt = 0.
- Forced burst as above, gfx_req dropped after 2 beats -> burst ends, the drop cycle has no grant, the next cycle grants the CPU.
- Assert reset on the 2nd burst beat, with a gfx read issued the previous cycle -> next cycle: state ARB, gfx_rvalid = 0, wait_cnt = 0, mem_en = 0 during the reset cycle.
- Alternating CPU read/write with no gfx traffic for 20 cycles -> cpu_stall never asserted; rvalid follows each read by exactly 1 cycle.
